// File: rtl/count_window_ctrl.sv
// Measurement-window controller for an external 4-bit event counter.
// Extends the count with a wrap counter and reports a saturating 8-bit total.
module count_window_ctrl #(
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             event_in,
  input  logic [3:0]       cnt_val,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             ovf
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    REPORT
  } state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [3:0]       wrap_q, wrap_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       result_q, result_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wrap_d   = wrap_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = CLEAR;
          rem_d    = win_len;
          wrap_d   = 4'h0;
          sticky_d = 1'b0;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        if (abort)
          state_d = IDLE;
        else if (rem_q != '0)
          state_d = RUN;
        else
          state_d = SETTLE;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_en = event_in;
          rem_d  = rem_q - WIN_W'(1);
          // Counter rolls over on this edge; count the wrap here.
          if (event_in && cnt_val == 4'hF) begin
            if (wrap_q == 4'hF)
              sticky_d = 1'b1;
            else
              wrap_d = wrap_q + 4'h1;
          end
          if (rem_q == WIN_W'(1))
            state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          result_d = sticky_q ? 8'hFF : {wrap_q, cnt_val};
          ovf_d    = sticky_q;
          state_d  = REPORT;
        end
      end
      REPORT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      wrap_q   <= 4'h0;
      sticky_q <= 1'b0;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
